// File: rtl/cmult_arbiter.sv
// Two-requester round-robin front end for a shared pipelined complex multiplier.
// Per-requester result FIFOs, with credits that reserve FIFO space before a request issues.
module cmult_arbiter #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [17:0] req0_a,
    input  logic signed [17:0] req0_b,
    input  logic signed [17:0] req0_c,
    input  logic signed [17:0] req0_d,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [17:0] req1_a,
    input  logic signed [17:0] req1_b,
    input  logic signed [17:0] req1_c,
    input  logic signed [17:0] req1_d,
    output logic signed [17:0] mult_a,
    output logic signed [17:0] mult_b,
    output logic signed [17:0] mult_c,
    output logic signed [17:0] mult_d,
    input  logic signed [37:0] mult_real,
    input  logic signed [37:0] mult_imag,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic signed [37:0] resp0_real,
    output logic signed [37:0] resp0_imag,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic signed [37:0] resp1_real,
    output logic signed [37:0] resp1_imag,
    output logic               busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [1:0] req_valid, resp_ready, elig, grant, push, pop, resp_valid, nonempty;
    logic       rr_q, rr_d;
    logic [LAT-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
    logic signed [37:0] head_re [2];
    logic signed [37:0] head_im [2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};

    // rr_q holds the id granted most recently; the other requester wins a tie.
    assign grant[0] = elig[0] && (!elig[1] || rr_q);
    assign grant[1] = elig[1] && (!elig[0] || !rr_q);

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        rr_d   = rr_q;
        mult_a = '0;
        mult_b = '0;
        mult_c = '0;
        mult_d = '0;
        if (grant[0]) begin
            rr_d   = 1'b0;
            mult_a = req0_a;
            mult_b = req0_b;
            mult_c = req0_c;
            mult_d = req0_d;
        end else if (grant[1]) begin
            rr_d   = 1'b1;
            mult_a = req1_a;
            mult_b = req1_b;
            mult_c = req1_c;
            mult_d = req1_d;
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = |grant;
        tag_id_d[0]  = grant[1];
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tag_vld_q <= '0;
            rr_q      <= 1'b1;
        end else begin
            tag_vld_q <= tag_vld_d;
            rr_q      <= rr_d;
        end
        tag_id_q <= tag_id_d;
    end

    for (genvar g = 0; g < 2; g++) begin : gen_req
        logic signed [37:0] mem_re_q [DEPTH];
        logic signed [37:0] mem_im_q [DEPTH];
        logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CNT_W-1:0]   count_q, count_d, credit_q, credit_d;

        assign elig[g]       = reset_n && req_valid[g] && (credit_q < DEPTH_C);
        assign push[g]       = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == 1'(g));
        assign nonempty[g]   = (count_q != '0);
        assign resp_valid[g] = reset_n && nonempty[g];
        assign pop[g]        = resp_valid[g] && resp_ready[g];
        assign head_re[g]    = mem_re_q[rptr_q];
        assign head_im[g]    = mem_im_q[rptr_q];

        always_comb begin
            wptr_d   = push[g] ? ptr_inc(wptr_q) : wptr_q;
            rptr_d   = pop[g]  ? ptr_inc(rptr_q) : rptr_q;
            count_d  = count_q;
            credit_d = credit_q;
            if (push[g] && !pop[g]) begin
                count_d = count_q + CNT_ONE;
            end else if (pop[g] && !push[g]) begin
                count_d = count_q - CNT_ONE;
            end
            // Credit spans issue to pop, so FIFO space is reserved before the tag leaves.
            if (grant[g] && !pop[g]) begin
                credit_d = credit_q + CNT_ONE;
            end else if (pop[g] && !grant[g]) begin
                credit_d = credit_q - CNT_ONE;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                wptr_q   <= '0;
                rptr_q   <= '0;
                count_q  <= '0;
                credit_q <= '0;
            end else begin
                wptr_q   <= wptr_d;
                rptr_q   <= rptr_d;
                count_q  <= count_d;
                credit_q <= credit_d;
            end
        end

        always_ff @(posedge clock) begin
            if (push[g]) begin
                mem_re_q[wptr_q] <= mult_real;
                mem_im_q[wptr_q] <= mult_imag;
            end
        end
    end

    assign resp0_valid = resp_valid[0];
    assign resp1_valid = resp_valid[1];
    assign resp0_real  = head_re[0];
    assign resp0_imag  = head_im[0];
    assign resp1_real  = head_re[1];
    assign resp1_imag  = head_im[1];

    assign busy = (|tag_vld_q) || (|nonempty);

endmodule

// File: tb/tb_cmult_arbiter.sv
// Bench for cmult_arbiter: ideal 3-stage multiplier, directed vectors, queue scoreboard.
module tb_cmult_arbiter;

    logic clock = 1'b0;
    logic reset_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic signed [17:0] req0_a, req0_b, req0_c, req0_d;
    logic signed [17:0] req1_a, req1_b, req1_c, req1_d;
    logic signed [17:0] mult_a, mult_b, mult_c, mult_d;
    logic signed [37:0] mult_real, mult_imag;
    logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic signed [37:0] resp0_real, resp0_imag, resp1_real, resp1_imag;
    logic busy;

    always #5 clock = ~clock;

    cmult_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_d(req0_d),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_d(req1_d),
        .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_d(mult_d),
        .mult_real(mult_real), .mult_imag(mult_imag),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_real(resp0_real), .resp0_imag(resp0_imag),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_real(resp1_real), .resp1_imag(resp1_imag),
        .busy(busy)
    );

    // Environment multiplier: three register stages from operands to result.
    logic signed [37:0] ea, eb, ec, ed;
    logic signed [37:0] pre_q [3];
    logic signed [37:0] pim_q [3];
    assign ea = 38'(mult_a);
    assign eb = 38'(mult_b);
    assign ec = 38'(mult_c);
    assign ed = 38'(mult_d);
    always @(posedge clock) begin
        pre_q[0] <= ea * ec - eb * ed;
        pim_q[0] <= ea * ed + eb * ec;
        pre_q[1] <= pre_q[0];
        pim_q[1] <= pim_q[0];
        pre_q[2] <= pre_q[1];
        pim_q[2] <= pim_q[1];
    end
    assign mult_real = pre_q[2];
    assign mult_imag = pim_q[2];

    // Directed vectors with hand-computed (a+jb)*(c+jd).
    logic signed [17:0] va [8] = '{18'sd3, 18'sd1, -18'sd2, 18'sd10, 18'sh20000, 18'sd100, 18'sd7, 18'sd131071};
    logic signed [17:0] vb [8] = '{18'sd4, 18'sd0, 18'sd3, -18'sd1, 18'sh20000, 18'sd200, 18'sd7, 18'sd0};
    logic signed [17:0] vc [8] = '{18'sd5, 18'sd1, 18'sd4, 18'sd2, 18'sh20000, -18'sd3, 18'sd7, 18'sd131071};
    logic signed [17:0] vd [8] = '{18'sd6, 18'sd0, -18'sd5, 18'sd7, 18'sh20000, 18'sd2, -18'sd7, 18'sd0};
    logic signed [37:0] vre [8] = '{-38'sd9, 38'sd1, 38'sd7, 38'sd27, 38'sd0, -38'sd700, 38'sd98, 38'sd17179607041};
    logic signed [37:0] vim [8] = '{38'sd38, 38'sd0, 38'sd22, 38'sd68, 38'sd34359738368, -38'sd400, 38'sd0, 38'sd0};

    int n_checks = 0;
    int n_fail   = 0;
    int idx0, idx1;
    logic signed [37:0] exp0_re, exp0_im, exp1_re, exp1_im;
    logic signed [37:0] q0_re[$], q0_im[$], q1_re[$], q1_im[$];

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Expected results are queued at the moment a transfer is accepted.
    always @(negedge clock) begin
        if (!reset_n) begin
            q0_re.delete(); q0_im.delete(); q1_re.delete(); q1_im.delete();
        end else begin
            if (req0_valid && req0_ready) begin q0_re.push_back(exp0_re); q0_im.push_back(exp0_im); end
            if (req1_valid && req1_ready) begin q1_re.push_back(exp1_re); q1_im.push_back(exp1_im); end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (resp0_valid && resp0_ready) begin
                if (q0_re.size() == 0) check("resp0_unexpected_pop", 1, 0);
                else begin
                    check("resp0_real", resp0_real, q0_re.pop_front());
                    check("resp0_imag", resp0_imag, q0_im.pop_front());
                end
            end
            if (resp1_valid && resp1_ready) begin
                if (q1_re.size() == 0) check("resp1_unexpected_pop", 1, 0);
                else begin
                    check("resp1_real", resp1_real, q1_re.pop_front());
                    check("resp1_imag", resp1_imag, q1_im.pop_front());
                end
            end
        end
    end

    task automatic drive_ops();
        int j0, j1;
        j0 = idx0 % 8;
        j1 = (idx1 + 3) % 8;
        req0_a = va[j0]; req0_b = vb[j0]; req0_c = vc[j0]; req0_d = vd[j0];
        exp0_re = vre[j0]; exp0_im = vim[j0];
        req1_a = va[j1]; req1_b = vb[j1]; req1_c = vc[j1]; req1_d = vd[j1];
        exp1_re = vre[j1]; exp1_im = vim[j1];
    endtask

    task automatic next_cycle();
        if (req0_valid && req0_ready) idx0++;
        if (req1_valid && req1_ready) idx1++;
        @(posedge clock); #1;
    endtask

    task automatic drain();
        int k;
        req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
        k = 0;
        @(negedge clock);
        while (busy && k < 40) begin
            @(posedge clock); #1; @(negedge clock); k++;
        end
        check("drain_busy", busy, 0);
        check("drain_q0_empty", q0_re.size(), 0);
        check("drain_q1_empty", q1_re.size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic single(input int v);
        idx0 = v; resp0_ready = 1; resp1_ready = 1;
        req0_valid = 1; req1_valid = 0; drive_ops();
        @(negedge clock);
        check("single_ready", req0_ready, 1);
        check("single_mult_a", mult_a, va[v]);
        next_cycle();
        req0_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            check("single_latency_valid", resp0_valid, (k == 4) ? 1 : 0);
            if (k == 1) check("idle_mult_a", mult_a, 0);
            @(posedge clock); #1;
        end
    endtask

    task automatic reset_pulse();
        reset_n = 0;
        @(posedge clock); #1;
        reset_n = 1;
    endtask

    initial begin
        int g0cnt, g1win;
        reset_n = 0; req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        idx0 = 0; idx1 = 0; drive_ops();
        repeat (2) @(posedge clock);
        #1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clock);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        check("rst_resp1_valid", resp1_valid, 0);
        check("rst_mult_a", mult_a, 0);
        @(posedge clock); #1;
        reset_n = 1; req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        check("post_rst_busy", busy, 0);
        check("post_rst_resp0_valid", resp0_valid, 0);
        @(posedge clock); #1;

        single(0);
        single(4);
        drain();

        // Alternating grants after reset, requester 0 first.
        reset_pulse();
        resp0_ready = 1; resp1_ready = 1; req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 16; k++) begin
            drive_ops();
            @(negedge clock);
            check("alt_grant0", req0_ready, (k % 2 == 0) ? 1 : 0);
            check("alt_grant1", req1_ready, (k % 2 == 1) ? 1 : 0);
            next_cycle();
        end
        drain();

        // Credit limit on requester 0 while requester 1 keeps streaming.
        resp0_ready = 0; resp1_ready = 1; req0_valid = 1; req1_valid = 1;
        g0cnt = 0; g1win = 0;
        for (int k = 0; k < 30; k++) begin
            drive_ops();
            @(negedge clock);
            if (req0_ready) g0cnt++;
            if (k >= 10 && req1_ready) g1win++;
            next_cycle();
        end
        check("credit_req0_grants", g0cnt, 4);
        check("credit_req1_rate", (g1win >= 16) ? 1 : 0, 1);
        resp0_ready = 1; drive_ops();
        @(negedge clock);
        check("pop_cycle_resp0_valid", resp0_valid, 1);
        check("pop_cycle_req0_ready", req0_ready, 0);
        next_cycle();
        resp0_ready = 0; g0cnt = 0;
        for (int k = 0; k < 12; k++) begin
            drive_ops();
            @(negedge clock);
            if (req0_ready) g0cnt++;
            next_cycle();
        end
        check("after_pop_req0_grants", g0cnt, 1);
        drain();

        // Reset with one result queued and two tags in flight.
        resp0_ready = 0; resp1_ready = 0; req1_valid = 0;
        req0_valid = 1; drive_ops();
        @(negedge clock);
        check("r_first_ready", req0_ready, 1);
        next_cycle();
        req0_valid = 0;
        repeat (4) begin @(posedge clock); #1; end
        for (int k = 0; k < 2; k++) begin
            req0_valid = 1; drive_ops();
            @(negedge clock);
            check("r_inflight_ready", req0_ready, 1);
            next_cycle();
        end
        reset_n = 0; drive_ops();
        @(negedge clock);
        check("r_mid_busy_before", busy, 1);
        check("r_mid_req0_ready", req0_ready, 0);
        check("r_mid_resp0_valid", resp0_valid, 0);
        check("r_mid_mult_a", mult_a, 0);
        next_cycle();
        reset_n = 1; req0_valid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("r_after_resp0_valid", resp0_valid, 0);
            check("r_after_busy", busy, 0);
            @(posedge clock); #1;
        end
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1; drive_ops();
            @(negedge clock);
            check("r_b2b_ready", req0_ready, (k < 4) ? 1 : 0);
            next_cycle();
        end
        drain();

        // Fill FIFO 0, then stream with coincident writes and pops so pointers wrap.
        resp0_ready = 0; req1_valid = 0;
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1; drive_ops();
            @(negedge clock);
            check("fill_ready", req0_ready, (k < 4) ? 1 : 0);
            next_cycle();
        end
        req0_valid = 0;
        repeat (4) begin @(posedge clock); #1; end
        @(negedge clock);
        check("full_resp0_valid", resp0_valid, 1);
        @(posedge clock); #1;
        for (int k = 0; k < 24; k++) begin
            req0_valid = 1; resp0_ready = (k % 3 != 0); drive_ops();
            @(negedge clock);
            next_cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
